// File: rtl/rv32_uart_peripheral.sv
// Memory-mapped UART at 0x2000_0000-0x2000_001F: TXDATA, RXDATA, STATUS, BAUD_DIV, byte FIFOs, 8N1 framing.
// Define RV32_UART_PARITY_EN to insert an even parity bit in both directions (STATUS[7] parity_err).
module rv32_uart_peripheral #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef RV32_UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

    logic        hit, we_any, stat_wr;
    logic [2:0]  sel;
    logic [15:0] baud_q, per, half;
    logic [31:0] rd_data, mem_data_q;
    logic        unused_bits;

    assign hit     = mem_addr_i[31:5] == 27'h100_0000;
    assign sel     = mem_addr_i[4:2];
    assign we_any  = |mem_we_i;
    assign stat_wr = hit && sel == 3'd2 && mem_we_i[0];
    assign per     = (baud_q < 16'd2) ? 16'd2 : baud_q;
    assign half    = per >> 1;
    assign unused_bits = ^{mem_data_i[31:16], mem_addr_i[1:0]};

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic        tx_empty, tx_full, tx_push, tx_pop;
    logic        rx_empty, rx_full, rx_push, rx_pop;
    logic [7:0]  tx_head, rx_head;

    // Full when the wrap bits differ but the indices match.
    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign rx_empty = rx_wp_q == rx_rp_q;
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
    assign rx_head  = rx_mem[rx_rp_q[AW-1:0]];

    state_t      tx_state_q, rx_state_q;
    logic [15:0] tx_cnt_q, rx_cnt_q;
    logic [2:0]  tx_bit_q, rx_bit_q;
    logic [7:0]  tx_sh_q, rx_sh_q;
    logic        tx_q, tx_par_q, rx_par_bad_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        overrun_q, frame_err_q, parity_err_q;
    logic        stop_ok, stop_bad;

    assign tx_push  = hit && sel == 3'd0 && mem_we_i[0] && !tx_full;
    assign tx_pop   = !tx_empty && (tx_state_q == S_IDLE || (tx_state_q == S_STOP && tx_cnt_q == 16'd0));
    assign stop_ok  = rx_state_q == S_STOP && rx_cnt_q == 16'd0 && rx_s2_q;
    assign stop_bad = rx_state_q == S_STOP && rx_cnt_q == 16'd0 && !rx_s2_q;
    assign rx_push  = stop_ok && !rx_full;
    assign rx_pop   = hit && sel == 3'd1 && we_any && !rx_empty;
    assign uart_tx_o  = tx_q;
    assign mem_data_o = mem_data_q;

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= mem_data_i[7:0];
        if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
    end

    always_comb begin
        rd_data = 32'd0;
        if (hit) begin
            case (sel)
                3'd1:    rd_data = {!rx_empty, 23'd0, rx_head};
                3'd2:    rd_data = {24'd0, parity_err_q, tx_state_q != S_IDLE, frame_err_q, overrun_q,
                                    rx_full, rx_empty, tx_empty, tx_full};
                3'd3:    rd_data = {16'd0, baud_q};
                default: rd_data = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
            baud_q <= DEFAULT_DIV;
            mem_data_q <= 32'd0;
            overrun_q <= 1'b0; frame_err_q <= 1'b0; parity_err_q <= 1'b0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            if (hit && sel == 3'd3 && mem_we_i[0]) baud_q[7:0]  <= mem_data_i[7:0];
            if (hit && sel == 3'd3 && mem_we_i[1]) baud_q[15:8] <= mem_data_i[15:8];
            mem_data_q <= rd_data;
            // A set in the same cycle as a clear wins.
            overrun_q    <= (stop_ok && rx_full) || (overrun_q && !(stat_wr && mem_data_i[4]));
            frame_err_q  <= stop_bad || (frame_err_q && !(stat_wr && mem_data_i[5]));
            parity_err_q <= PAR_EN && ((stop_ok && rx_par_bad_q) || (parity_err_q && !(stat_wr && mem_data_i[7])));
        end
    end

    // Bit counters load at each bit boundary, so a BAUD_DIV change only affects the next bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state_q <= S_IDLE; tx_q <= 1'b1; tx_cnt_q <= 16'd0;
            tx_bit_q <= 3'd0; tx_sh_q <= 8'd0; tx_par_q <= 1'b0;
        end else begin
            case (tx_state_q)
                S_IDLE, S_STOP: begin
                    if (tx_state_q == S_STOP && tx_cnt_q != 16'd0) begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end else if (tx_pop) begin
                        tx_state_q <= S_START; tx_q <= 1'b0; tx_cnt_q <= per - 16'd1;
                        tx_sh_q <= tx_head; tx_par_q <= ^tx_head;
                    end else begin
                        tx_state_q <= S_IDLE; tx_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_state_q <= S_DATA; tx_q <= tx_sh_q[0]; tx_cnt_q <= per - 16'd1; tx_bit_q <= 3'd0;
                    end else tx_cnt_q <= tx_cnt_q - 16'd1;
                end
                S_DATA: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_cnt_q <= per - 16'd1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= PAR_EN ? S_PARITY : S_STOP;
                            tx_q <= PAR_EN ? tx_par_q : 1'b1;
                        end else begin
                            tx_sh_q <= {1'b0, tx_sh_q[7:1]}; tx_q <= tx_sh_q[1]; tx_bit_q <= tx_bit_q + 3'd1;
                        end
                    end else tx_cnt_q <= tx_cnt_q - 16'd1;
                end
                S_PARITY: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_state_q <= S_STOP; tx_q <= 1'b1; tx_cnt_q <= per - 16'd1;
                    end else tx_cnt_q <= tx_cnt_q - 16'd1;
                end
                default: begin
                    tx_state_q <= S_IDLE; tx_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
            rx_state_q <= S_IDLE; rx_cnt_q <= 16'd0; rx_bit_q <= 3'd0;
            rx_sh_q <= 8'd0; rx_par_bad_q <= 1'b0;
        end else begin
            rx_s1_q <= uart_rx_i; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= S_START; rx_cnt_q <= half - 16'd1; rx_par_bad_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                        rx_cnt_q <= per - 16'd1; rx_bit_q <= 3'd0;
                    end else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                S_DATA: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]}; rx_cnt_q <= per - 16'd1;
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= PAR_EN ? S_PARITY : S_STOP;
                    end else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                S_PARITY: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_par_bad_q <= rx_s2_q ^ (^rx_sh_q); rx_state_q <= S_STOP; rx_cnt_q <= per - 16'd1;
                    end else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                S_STOP: begin
                    if (rx_cnt_q == 16'd0) rx_state_q <= rx_s2_q ? S_IDLE : S_WAIT;
                    else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                default: begin
                    if (rx_s2_q) rx_state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_uart_peripheral.sv
// Bench for rv32_uart_peripheral: bus tasks, serial driver/collector, TX/RX expected-byte queues.
module tb_rv32_uart_peripheral;
    localparam logic [31:0] A_TX = 32'h2000_0000;
    localparam logic [31:0] A_RX = 32'h2000_0004;
    localparam logic [31:0] A_ST = 32'h2000_0008;
    localparam logic [31:0] A_BD = 32'h2000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mem_we = 4'h0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_data = 32'd0;
    logic [31:0] mem_rdata;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    rv32_uart_peripheral #(.FIFO_DEPTH(16), .DEFAULT_DIV(16'd16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_data_i(mem_data), .mem_data_o(mem_rdata), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        @(negedge clk);
        mem_addr = a; mem_data = d; mem_we = we;
        @(posedge clk);
        #1 mem_we = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        mem_addr = a; mem_we = 4'h0;
        @(negedge clk);
        d = mem_rdata;
    endtask

    task automatic rx_send(input logic [7:0] b, input int per, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (per) @(negedge clk);
        end
        uart_rx = stop;
        repeat (per) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic tx_collect(input int n, input int per);
        for (int k = 0; k < n; k++) begin
            int w;
            logic [7:0] got;
            logic [7:0] exp;
            w = 0;
            while (uart_tx !== 1'b0 && w < 40 * per + 200) begin
                @(negedge clk);
                w++;
            end
            n_cmp++;
            if (uart_tx !== 1'b0) begin
                n_bad++;
                $display("FAIL tx_start_timeout: line %b after %0d cycles, required 0", uart_tx, w);
                return;
            end
            repeat (per / 2) @(negedge clk);
            n_cmp++;
            if (uart_tx !== 1'b0) begin
                n_bad++;
                $display("FAIL tx_start_mid: line %b, required 0", uart_tx);
            end
            for (int i = 0; i < 8; i++) begin
                repeat (per) @(negedge clk);
                got[i] = uart_tx;
            end
            repeat (per) @(negedge clk);
            n_cmp++;
            if (uart_tx !== 1'b1) begin
                n_bad++;
                $display("FAIL tx_stop_bit: line %b, required 1", uart_tx);
            end
            n_cmp++;
            if (tx_exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL tx_unexpected: got byte %h, required no frame", got);
            end else begin
                exp = tx_exp_q.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL tx_byte: got %h, required %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b, required 1", uart_tx); end
        n_cmp++;
        if (mem_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h, required 0", mem_rdata); end
        rst_n = 1'b1;
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h6) begin n_bad++; $display("FAIL reset_status: got %h, required 00000006", d); end
        bus_read(A_BD, d);
        n_cmp++;
        if (d !== 32'd16) begin n_bad++; $display("FAIL reset_baud: got %h, required 00000010", d); end
        bus_read(A_RX, d);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL reset_rxdata: got %h, required 0", d); end
    endtask

    task automatic test_tx_frame();
        logic [9:0] frame;
        int w;
        frame = {1'b1, 8'hA5, 1'b0};
        bus_write(A_TX, 32'hA5, 4'b0001);
        mem_addr = A_ST;
        w = 0;
        while (uart_tx !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 160; i++) begin
            n_cmp++;
            if (uart_tx !== frame[i / 16]) begin
                n_bad++;
                $display("FAIL tx_frame_bit: cycle %0d line %b, required %b", i, uart_tx, frame[i / 16]);
            end
            if (i >= 1) begin
                n_cmp++;
                if (mem_rdata[6] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL tx_busy: cycle %0d got %b, required 1", i, mem_rdata[6]);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL tx_frame_idle: got %b, required 1", uart_tx); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        int lows;
        bus_write(A_BD, 32'd8, 4'b0011);
        fork
            tx_collect(17, 8);
            begin
                tx_exp_q.push_back(8'hFF);
                bus_write(A_TX, 32'hFF, 4'b0001);
                repeat (4) @(negedge clk);
                for (int i = 0; i < 17; i++) begin
                    bus_write(A_TX, i, 4'b0001);
                    if (i < 16) tx_exp_q.push_back(8'(i));
                end
                bus_read(A_ST, d);
                n_cmp++;
                if (d[1:0] !== 2'b01) begin
                    n_bad++;
                    $display("FAIL tx_full_flag: status[1:0] %b, required 01", d[1:0]);
                end
            end
        join
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx === 1'b0) lows++;
        end
        n_cmp++;
        if (lows != 0 || tx_exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL tx_overflow_extra: low cycles %0d pending %0d, required 0 and 0", lows, tx_exp_q.size());
        end
    endtask

    task automatic test_rx_receive();
        logic [31:0] d;
        logic [7:0] exp;
        bus_write(A_BD, 32'd16, 4'b0011);
        rx_exp_q.push_back(8'h3C);
        rx_send(8'h3C, 16, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h2) begin n_bad++; $display("FAIL rx_status: got %h, required 00000002", d); end
        bus_read(A_RX, d);
        exp = rx_exp_q.pop_front();
        n_cmp++;
        if (d !== {1'b1, 23'd0, exp}) begin
            n_bad++;
            $display("FAIL rx_data: got %h, required %h", d, {1'b1, 23'd0, exp});
        end
        bus_write(A_RX, 32'd0, 4'hF);
        bus_read(A_RX, d);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL rx_after_pop: got %h, required 0", d); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] d;
        logic [7:0] exp;
        logic [7:0] b;
        rx_send(8'h55, 16, 1'b0);
        repeat (20) @(negedge clk);
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h26) begin n_bad++; $display("FAIL rx_frame_err: got %h, required 00000026", d); end
        bus_write(A_ST, 32'h20, 4'b0001);
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h6) begin n_bad++; $display("FAIL rx_frame_clear: got %h, required 00000006", d); end
        for (int k = 0; k < 17; k++) begin
            b = 8'($urandom_range(0, 255));
            if (k < 16) rx_exp_q.push_back(b);
            rx_send(b, 16, 1'b1);
        end
        repeat (4) @(negedge clk);
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h1A) begin n_bad++; $display("FAIL rx_overrun: got %h, required 0000001a", d); end
        while (rx_exp_q.size() != 0) begin
            bus_read(A_RX, d);
            exp = rx_exp_q.pop_front();
            n_cmp++;
            if (d !== {1'b1, 23'd0, exp}) begin
                n_bad++;
                $display("FAIL rx_fifo_head: got %h, required %h", d, {1'b1, 23'd0, exp});
            end
            bus_write(A_RX, 32'd0, 4'b0001);
        end
        bus_write(A_ST, 32'h10, 4'b0001);
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h6) begin n_bad++; $display("FAIL rx_overrun_clear: got %h, required 00000006", d); end
    endtask

    task automatic test_glitch_reset();
        logic [31:0] d;
        int lows;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h6) begin n_bad++; $display("FAIL rx_glitch: got %h, required 00000006", d); end
        bus_write(A_BD, 32'd20, 4'b0011);
        bus_write(A_TX, 32'h00, 4'b0001);
        bus_write(A_TX, 32'h00, 4'b0001);
        mem_addr = A_BD;
        repeat (50) @(negedge clk);
        n_cmp++;
        if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL pre_reset_tx: got %b, required 0", uart_tx); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL async_reset_tx: got %b, required 1", uart_tx); end
        n_cmp++;
        if (mem_rdata !== 32'd0) begin n_bad++; $display("FAIL async_reset_rdata: got %h, required 0", mem_rdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_BD, d);
        n_cmp++;
        if (d !== 32'd16) begin n_bad++; $display("FAIL post_reset_baud: got %h, required 00000010", d); end
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h6) begin n_bad++; $display("FAIL post_reset_status: got %h, required 00000006", d); end
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (uart_tx === 1'b0) lows++;
        end
        n_cmp++;
        if (lows != 0) begin n_bad++; $display("FAIL post_reset_idle: low cycles %0d, required 0", lows); end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        int w;
        int lows;
        bus_write(A_BD, 32'h1234, 4'b0001);
        bus_read(A_BD, d);
        n_cmp++;
        if (d !== 32'h34) begin n_bad++; $display("FAIL baud_bytelane: got %h, required 00000034", d); end
        bus_write(32'h2000_0020, 32'h77, 4'b0001);
        bus_read(32'h2000_0020, d);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL decode_miss: got %h, required 0", d); end
        bus_read(32'h2000_0010, d);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL decode_reserved: got %h, required 0", d); end
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h6) begin n_bad++; $display("FAIL decode_miss_write: got %h, required 00000006", d); end
        bus_write(A_BD, 32'd1, 4'b0011);
        tx_exp_q.push_back(8'h55);
        fork
            tx_collect(1, 2);
            bus_write(A_TX, 32'h55, 4'b0001);
        join
        bus_write(A_TX, 32'h00, 4'b0001);
        w = 0;
        while (uart_tx !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        lows = 0;
        while (uart_tx === 1'b0 && lows < 100) begin
            lows++;
            @(negedge clk);
        end
        n_cmp++;
        if (lows != 18) begin n_bad++; $display("FAIL min_period: low run %0d cycles, required 18", lows); end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_tx_overflow();
        test_rx_receive();
        test_rx_errors();
        test_glitch_reset();
        test_decode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv32_uart_peripheral.md
Name: rv32_uart_peripheral

Overview:
- Memory-mapped UART responder on the core's peripheral data bus, decoded at 0x2000_0000–0x2000_001F.
- Answers the core's byte-enabled write and word read accesses: four registers, TX/RX byte FIFOs, one shared baud divider, 8N1 serial framing.
- Sits behind the peripheral datapath write-enable demux.
- Read data is registered: it returns one cycle after the address, matching the core's second memory stage.

Parameters:
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, ≥2.
- DEFAULT_DIV, 868, reset value of BAUD_DIV in clock cycles per bit (100 MHz / 115200).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- mem_we_i  in  4  byte write enables; nonzero means write cycle
- mem_addr_i  in  32  byte address from core
- mem_data_i  in  32  write data
- mem_data_o  out  32  registered read data
- uart_rx_i  in  1  serial input, asynchronous, idle high
- uart_tx_o  out  1  serial output, idle high

Behaviour:
- Decided interface: one clock `clk_i`; reset `rst_n_i` is asynchronous and active-low.
- Hit decode: mem_addr_i[31:5] == 27'h100_0000. On a miss, writes are ignored and mem_data_o is 0 next cycle.
- Register select is mem_addr_i[4:2]; offsets 0x10–0x1C read 0 and ignore writes.
- mem_data_o is registered. Value for the address at cycle N appears at N+1. Reads have no side effects.
- Register 0x00 TXDATA:
  - W with we[0]: push [7:0] to TX FIFO.
  - If the FIFO is full (count before this cycle), the push is dropped silently, even if the engine pops in the same cycle.
  - Reads return 0.
- Register 0x04 RXDATA:
  - R: [7:0] is the RX FIFO head, [31] = !rx_empty, other bits 0.
  - Any write (we != 0) pops one entry. A pop when empty is ignored.
- Register 0x08 STATUS:
  - R: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] rx_overrun (sticky), [5] frame_err (sticky), [6] tx_busy.
  - W with we[0]: 1 in bit 4 or 5 clears that bit. If a set and a clear hit the same cycle, the set wins.
- Register 0x0C BAUD_DIV:
  - [15:0] read/write, byte-laned by we[1:0]; [31:16] read 0.
  - Effective bit period = max(BAUD_DIV, 2) cycles.
  - A change affects the next bit boundary, not the current bit.
- TX engine FSM IDLE→START→DATA→STOP→IDLE:
  - IDLE pops the FIFO when it is non-empty.
  - Each state holds one bit period. DATA shifts out 8 bits LSB first. STOP drives 1.
  - After STOP, the engine goes directly to START if the FIFO is non-empty (back-to-back frames, no idle gap).
  - tx_busy = state != IDLE.
- RX engine:
  - 2-flop synchronizer, reset value 1.
  - FSM IDLE→START→DATA→STOP.
  - IDLE: a falling edge starts a half-period count. At the midpoint, a 0 enters DATA; a 1 means a false start and returns to IDLE.
  - DATA samples every full period at mid-bit, 8 bits, LSB first.
  - STOP samples at mid-bit:
    - 1: push byte; if the RX FIFO is full, drop the byte and set rx_overrun.
    - 0: set frame_err, discard the byte, wait for line high before returning to IDLE.
- FIFOs:
  - Circular with log2(FIFO_DEPTH)+1-bit pointers; full/empty come from the MSB compare.
  - Bus pop and engine push in the same cycle are both honoured.
- Reset (async, including mid-frame) gives:
  - uart_tx_o=1 immediately, mem_data_o=0;
  - FIFOs empty, status sticky bits 0;
  - BAUD_DIV=DEFAULT_DIV, both FSMs IDLE;
  - partial frames discarded.

Optional Feature:
- Macro RV32_UART_PARITY_EN.
- Defined:
  - An even parity bit is inserted between DATA and STOP in both engines (PARITY state).
  - An RX parity mismatch sets sticky STATUS[7] parity_err; the byte is still pushed. STATUS[7] clears by writing 1.
- Undefined:
  - 8N1 only, no PARITY state; STATUS[7] reads 0 and writes to it are ignored.

Test Plan:
- TX frame: DEFAULT_DIV=16; write 0x2000_0000 = 0xA5 with we=4'b0001. Required: uart_tx_o low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles; tx_busy=1 throughout the frame.
- TX overflow: with the engine stalled mid-frame, push 17 bytes 0x00..0x10 (FIFO_DEPTH=16). Required: STATUS[0]=1; output frames are 0x00..0x0F; 0x10 is never sent.
- RX receive: drive 0x3C at 16 cycles/bit. Required: STATUS[2] goes 0; a read of 0x2000_0004 returns 0x8000_003C one cycle later; a write to 0x04 pops it, then the read returns 0x0000_0000.
- RX errors:
  - Frame with stop bit 0: frame_err=1, FIFO unchanged; writing STATUS=0x20 clears it.
  - 17 frames with no pops: rx_overrun=1, and the head reads the first byte.
- Glitch and reset: a 4-cycle low pulse on uart_rx_i pushes nothing. Asserting rst_n_i=0 mid-TX-frame sets uart_tx_o=1 asynchronously; after release, BAUD_DIV reads 16 and the FIFOs are empty.
- Decode/latency: write BAUD_DIV=0x1234 with we=4'b0001 → reads 0x0000_0034 | (DEFAULT_DIV & 0xFF00). Read 0x2000_0020 → 0. Write BAUD_DIV=1 → measured bit period is 2 cycles.
